led_band_fc_chain_writer: RTL and testbench

Parametrised function-control (FC) writer for a daisy-chain of `N_DRIVERS` LED drivers on one LED band. It holds one `FC_WIDTH`-bit FC word per driver, loaded as a framed SPI transfer, and shifts the whole chain out on `SOUT`. The output runs between the FCWRTEN and WRTFC latch sequences issued by the band sync logic. It snapshots the configuration at write start, reloads its bit counter on every write, and reports sequencing and SPI framing errors.

---
 rtl/led_band_fc_chain_writer.sv | 193 +++++++++++++++++++
 tb/tb_led_band_fc_chain_writer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_band_fc_chain_writer.sv
// Function-control writer for a daisy chain of LED drivers. An SPI frame loads the chain
// configuration. The configuration is shifted out on SOUT between the FCWRTEN and WRTFC latch sequences.
module led_band_fc_chain_writer #(
    parameter int                  FC_WIDTH      = 48,
    parameter int                  N_DRIVERS     = 4,
    parameter logic [FC_WIDTH-1:0] DEFAULT_FC    = 48'h5c0201008048,
    parameter int                  FCWRTEN_SCLKS = 15,
    parameter int                  WRTFC_SCLKS   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic SCLK,
    input  logic LAT,
    output logic SOUT,
    output logic en,
    input  logic spi_clk,
    input  logic spi_data,
    input  logic spi_cs,
    input  logic err_clr,
    output logic seq_err,
    output logic spi_err,
    output logic cfg_valid
);
    localparam int TOTAL = N_DRIVERS * FC_WIDTH;
    localparam int SCW   = $clog2(TOTAL + 2);
    localparam int BCW   = $clog2(TOTAL + 1);
    localparam logic [SCW-1:0] SPI_FULL = SCW'(TOTAL);
    localparam logic [SCW-1:0] SPI_SAT  = SCW'(TOTAL + 1);
    localparam logic [BCW-1:0] BIT_LOAD = BCW'(TOTAL);
    localparam logic [4:0]     FCW_CNT  = 5'(FCWRTEN_SCLKS);
    localparam logic [4:0]     WRT_CNT  = 5'(WRTFC_SCLKS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    logic [TOTAL-1:0] w_default;
    generate
        for (genvar gi = 0; gi < N_DRIVERS; gi++) begin : g_default
            assign w_default[gi*FC_WIDTH +: FC_WIDTH] = DEFAULT_FC;
        end
    endgenerate

    // Input sample stage plus previous-sample stage. An edge pulse is therefore seen one cycle after the input changes.
    logic r_sclk_s, r_sclk_p, r_lat_s;
    logic r_spi_clk_s, r_spi_clk_p, r_spi_cs_s, r_spi_cs_p, r_spi_data_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s     <= 1'b0;
            r_sclk_p     <= 1'b0;
            r_lat_s      <= 1'b0;
            r_spi_clk_s  <= 1'b0;
            r_spi_clk_p  <= 1'b0;
            r_spi_cs_s   <= 1'b0;
            r_spi_cs_p   <= 1'b0;
            r_spi_data_s <= 1'b0;
        end else begin
            r_sclk_s     <= SCLK;
            r_sclk_p     <= r_sclk_s;
            r_lat_s      <= LAT;
            r_spi_clk_s  <= spi_clk;
            r_spi_clk_p  <= r_spi_clk_s;
            r_spi_cs_s   <= spi_cs;
            r_spi_cs_p   <= r_spi_cs_s;
            r_spi_data_s <= spi_data;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_spi_clk_rise, w_cs_rise, w_cs_fall;
    assign w_sclk_rise    = r_sclk_s & ~r_sclk_p;
    assign w_sclk_fall    = ~r_sclk_s & r_sclk_p;
    assign w_spi_clk_rise = r_spi_clk_s & ~r_spi_clk_p;
    assign w_cs_rise      = r_spi_cs_s & ~r_spi_cs_p;
    assign w_cs_fall      = ~r_spi_cs_s & r_spi_cs_p;

    logic [4:0] r_lat_cnt;
    always_ff @(posedge clk) begin
        if (rst || !r_lat_s)
            r_lat_cnt <= 5'd0;
        else if (w_sclk_rise && r_lat_cnt != 5'd31)
            r_lat_cnt <= r_lat_cnt + 5'd1;
    end

    logic w_fcwrten, w_wrtfc;
    assign w_fcwrten = ~r_lat_s & (r_lat_cnt == FCW_CNT);
    assign w_wrtfc   = ~r_lat_s & (r_lat_cnt == WRT_CNT);

    logic [TOTAL-1:0] r_stage, r_active;
    logic [SCW-1:0]   r_spi_cnt;
    logic             r_cfg_valid;
    logic             w_spi_commit, w_spi_bad;
    assign w_spi_commit = w_cs_fall & (r_spi_cnt == SPI_FULL);
    assign w_spi_bad    = w_cs_fall & (r_spi_cnt != SPI_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage     <= '0;
            r_active    <= w_default;
            r_spi_cnt   <= '0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_cfg_valid <= w_spi_commit;
            if (w_cs_rise) begin
                r_spi_cnt <= '0;
            end else if (w_spi_clk_rise && r_spi_cs_s) begin
                r_stage <= {r_stage[TOTAL-2:0], r_spi_data_s};
                if (r_spi_cnt != SPI_SAT)
                    r_spi_cnt <= r_spi_cnt + 1'b1;
            end
            if (w_spi_commit)
                r_active <= r_stage;
        end
    end

    state_t           r_state, w_state_next;
    logic [TOTAL-1:0] r_shift;
    logic [BCW-1:0]   r_bit_cnt;
    logic             w_load, w_shift, w_seq_set;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_seq_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fcwrten) begin
                    w_state_next = S_SHIFT;
                    w_load       = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_fcwrten) begin
                    w_load    = 1'b1;
                    w_seq_set = 1'b1;
                end else if (w_wrtfc) begin
                    w_state_next = S_IDLE;
                    w_seq_set    = 1'b1;
                end else if (w_sclk_fall) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == BCW'(1))
                        w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_fcwrten) begin
                    w_state_next = S_SHIFT;
                    w_load       = 1'b1;
                end else if (w_wrtfc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The write runs from a snapshot, so SPI commits mid-write only affect the next write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= r_active;
            r_bit_cnt <= BIT_LOAD;
        end else if (w_shift) begin
            r_shift   <= {r_shift[TOTAL-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    logic r_seq_err, r_spi_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_err <= 1'b0;
            r_spi_err <= 1'b0;
        end else begin
            if (w_seq_set)    r_seq_err <= 1'b1;
            else if (err_clr) r_seq_err <= 1'b0;
            if (w_spi_bad)    r_spi_err <= 1'b1;
            else if (err_clr) r_spi_err <= 1'b0;
        end
    end

    assign SOUT      = (r_state == S_SHIFT) & r_shift[TOTAL-1];
    assign en        = (r_state == S_IDLE);
    assign seq_err   = r_seq_err;
    assign spi_err   = r_spi_err;
    assign cfg_valid = r_cfg_valid;
endmodule

// File: tb/tb_led_band_fc_chain_writer.sv
// Directed bench for the FC chain writer: default write, SPI loads, bad frames, early WRTFC,
// a commit during a write and a reset during a write.
module tb_led_band_fc_chain_writer;
    logic clk = 1'b0;
    logic rst, SCLK, LAT, SOUT, en;
    logic spi_clk, spi_data, spi_cs, err_clr, seq_err, spi_err, cfg_valid;

    led_band_fc_chain_writer dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT), .en(en),
        .spi_clk(spi_clk), .spi_data(spi_data), .spi_cs(spi_cs), .err_clr(err_clr),
        .seq_err(seq_err), .spi_err(spi_err), .cfg_valid(cfg_valid)
    );

    always #5 clk = ~clk;

    localparam logic [191:0] DEF = {4{48'h5c0201008048}};
    localparam logic [191:0] FA  = {48'hAAAAAAAAAAAA, {3{48'h123456789ABC}}};
    localparam logic [191:0] FB  = {48'hDEADBEEF0123, 48'h456789ABCDEF, 48'h0011223344FF, 48'hF0E1D2C3B4A5};

    int n_checks = 0;
    int n_fail   = 0;
    int cv_cnt   = 0;
    logic [191:0] cap;

    always @(negedge clk) if (cfg_valid === 1'b1) cv_cnt++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        SCLK = 1'b1; tick(3);
        SCLK = 1'b0; tick(3);
    endtask

    task automatic cap_pulse();
        SCLK = 1'b1; tick(3);
        cap = {cap[190:0], SOUT};
        SCLK = 1'b0; tick(3);
    endtask

    task automatic lat_seq(input int n);
        LAT = 1'b1; tick(1);
        repeat (n) pulse();
        LAT = 1'b0; tick(3);
    endtask

    task automatic full_write();
        lat_seq(15);
        cap = '0;
        repeat (192) cap_pulse();
        lat_seq(5);
    endtask

    task automatic spi_send(input logic [255:0] bits, input int n);
        spi_cs = 1'b1; tick(2);
        for (int i = n - 1; i >= 0; i--) begin
            spi_data = bits[i];
            spi_clk = 1'b0; tick(2);
            spi_clk = 1'b1; tick(2);
        end
        spi_clk = 1'b0; tick(2);
        spi_cs = 1'b0; tick(4);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1; tick(1);
        err_clr = 1'b0; tick(1);
    endtask

    initial begin
        rst = 1'b1; SCLK = 1'b0; LAT = 1'b0;
        spi_clk = 1'b0; spi_data = 1'b0; spi_cs = 1'b0; err_clr = 1'b0;
        cap = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_en", en, 1);
        chk("reset_sout", SOUT, 0);
        chk("reset_seq_err", seq_err, 0);
        chk("reset_spi_err", spi_err, 0);
        chk("reset_cfg_valid", cfg_valid, 0);

        // Default write with exact write-start latency
        LAT = 1'b1; tick(1);
        repeat (15) pulse();
        LAT = 1'b0; tick(1);
        chk("start_en_t1", en, 1);
        tick(1);
        chk("start_en_t2", en, 0);
        chk("start_sout_msb", SOUT, DEF[191]);
        tick(1);
        cap = '0;
        repeat (192) cap_pulse();
        chk("default_bits", cap, DEF);
        chk("done_en", en, 0);
        lat_seq(5);
        chk("wrtfc_en", en, 1);
        chk("default_seq_err", seq_err, 0);

        // Short and long frames
        spi_send({64'd0, FB}, 191);
        chk("short_spi_err", spi_err, 1);
        chk("short_cfg_valid", cv_cnt, 0);
        clear_errs();
        chk("clr_spi_err", spi_err, 0);
        spi_send({63'd0, 1'b1, FB}, 193);
        chk("long_spi_err", spi_err, 1);
        chk("long_cfg_valid", cv_cnt, 0);
        clear_errs();
        full_write();
        chk("badframe_bits", cap, DEF);

        // Good frame
        spi_send({64'd0, FA}, 192);
        chk("load_cfg_valid", cv_cnt, 1);
        chk("load_spi_err", spi_err, 0);
        full_write();
        chk("load_bits", cap, FA);

        // Early WRTFC after 100 bits
        lat_seq(15);
        cap = '0;
        repeat (100) cap_pulse();
        chk("early_first100", cap[99:0], FA[191:92]);
        lat_seq(5);
        chk("early_seq_err", seq_err, 1);
        chk("early_en", en, 1);
        clear_errs();
        chk("early_clr", seq_err, 0);
        full_write();
        chk("after_early_bits", cap, FA);
        chk("after_early_seq_err", seq_err, 0);

        // Commit in the middle of a write
        lat_seq(15);
        cap = '0;
        repeat (50) cap_pulse();
        spi_send({64'd0, FB}, 192);
        chk("mid_cfg_valid", cv_cnt, 2);
        repeat (142) cap_pulse();
        lat_seq(5);
        chk("mid_old_bits", cap, FA);
        chk("mid_seq_err", seq_err, 0);
        full_write();
        chk("mid_new_bits", cap, FB);

        // Reset in the middle of a write
        lat_seq(15);
        repeat (50) pulse();
        chk("prerst_en", en, 0);
        rst = 1'b1; tick(1);
        chk("rst_en", en, 1);
        chk("rst_sout", SOUT, 0);
        rst = 1'b0; tick(1);
        full_write();
        chk("rst_default_bits", cap, DEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
